brq_writeback: RTL and testbench

Writeback stage of the BURAQ RV32I core, directly upstream of the register file. Accepts retiring instructions from the execute/memory stage and selects the result: ALU value, PC+4, or aligned load data. For loads, waits for the data-memory response. Drives the register-file write port and exposes pending-load status for hazard detection.

---
 rtl/brq_wb_pkg.sv | 25 ++
 rtl/brq_writeback_if.sv | 40 ++++
 rtl/brq_load_align.sv | 46 ++++
 rtl/brq_writeback.sv | 164 ++++++++++++++++
 tb/tb_brq_writeback.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brq_wb_pkg.sv
// Shared types and constants for the BURAQ writeback stage.
package brq_wb_pkg;

  // Result source selected for a retiring instruction
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  // Writeback control state
  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // Load size/sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/brq_writeback_if.sv
// Execute/memory -> writeback -> register-file signal bundle.
interface brq_writeback_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrRegWidth = 5
);

  logic                    ex_valid_i;
  logic                    ex_ready_o;
  logic                    ex_wb_en_i;
  logic [1:0]              ex_wb_sel_i;
  logic [AddrRegWidth-1:0] ex_rd_i;
  logic [DataWidth-1:0]    ex_result_i;
  logic [DataWidth-1:0]    ex_pc_plus4_i;
  logic [2:0]              ex_funct3_i;
  logic                    dmem_rvalid_i;
  logic [DataWidth-1:0]    dmem_rdata_i;
  logic                    rf_we_o;
  logic [AddrRegWidth-1:0] rf_waddr_o;
  logic [DataWidth-1:0]    rf_wdata_o;
  logic                    pending_load_o;
  logic [AddrRegWidth-1:0] pending_rd_o;
  logic                    load_err_o;

  // Upstream pipeline and data memory side
  modport master (
    output ex_valid_i, ex_wb_en_i, ex_wb_sel_i, ex_rd_i, ex_result_i,
           ex_pc_plus4_i, ex_funct3_i, dmem_rvalid_i, dmem_rdata_i,
    input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           pending_load_o, pending_rd_o, load_err_o
  );

  // Writeback stage side
  modport slave (
    input  ex_valid_i, ex_wb_en_i, ex_wb_sel_i, ex_rd_i, ex_result_i,
           ex_pc_plus4_i, ex_funct3_i, dmem_rvalid_i, dmem_rdata_i,
    output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
           pending_load_o, pending_rd_o, load_err_o
  );

endinterface

// File: rtl/brq_load_align.sv
// Combinational load-data extractor/extender with alignment and funct3 checks.
module brq_load_align
  import brq_wb_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0] rdata_i,
  input  logic [1:0]           offset_i,
  input  logic [2:0]           funct3_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 misaligned_o,
  output logic                 illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane picked by the full offset, halfword lane by its upper bit
  assign byte_sel = 8'(rdata_i >> {offset_i, 3'b000});
  assign half_sel = 16'(rdata_i >> {offset_i[1], 4'b0000});

  // Size/sign decode and extension
  always_comb begin
    data_o       = '0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(DataWidth-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = DataWidth'(byte_sel);
      F3_LH: begin
        data_o       = {{(DataWidth-16){half_sel[15]}}, half_sel};
        misaligned_o = offset_i[0];
      end
      F3_LHU: begin
        data_o       = DataWidth'(half_sel);
        misaligned_o = offset_i[0];
      end
      F3_LW: begin
        data_o       = rdata_i;
        misaligned_o = (offset_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/brq_writeback.sv
// BURAQ RV32I writeback stage: result select, load wait/extract, RF write port.
module brq_writeback
  import brq_wb_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrRegWidth  = 5,
  parameter int unsigned TimeoutCycles = 255
) (
  input logic           brq_clk,
  input logic           brq_rst,
  brq_writeback_if.slave bus
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  wb_state_e               state_q, state_d;
  logic                    ex_ready_q, ex_ready_d;
  logic                    rf_we_q, rf_we_d;
  logic [AddrRegWidth-1:0] rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0]    rf_wdata_q, rf_wdata_d;
  logic                    load_err_q, load_err_d;
  logic                    pending_load_q, pending_load_d;
  logic [AddrRegWidth-1:0] pending_rd_q, pending_rd_d;
  logic [AddrRegWidth-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]              ld_f3_q, ld_f3_d;
  logic [1:0]              ld_off_q, ld_off_d;
  logic                    ld_wben_q, ld_wben_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  wb_sel_e                 sel;
  logic [1:0]              al_off;
  logic [2:0]              al_f3;
  logic [DataWidth-1:0]    al_data;
  logic                    al_misaligned;
  logic                    al_illegal;

  assign sel = wb_sel_e'(bus.ex_wb_sel_i);

  // One aligner: checks the incoming load in IDLE, extracts the response in WAIT_LOAD
  always_comb begin
    al_off = bus.ex_result_i[1:0];
    al_f3  = bus.ex_funct3_i;
    if (state_q == WAIT_LOAD) begin
      al_off = ld_off_q;
      al_f3  = ld_f3_q;
    end
  end

  brq_load_align #(
    .DataWidth(DataWidth)
  ) u_align (
    .rdata_i     (bus.dmem_rdata_i),
    .offset_i    (al_off),
    .funct3_i    (al_f3),
    .data_o      (al_data),
    .misaligned_o(al_misaligned),
    .illegal_o   (al_illegal)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    ld_wben_d  = ld_wben_q;
    cnt_d      = cnt_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    load_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ex_valid_i && ex_ready_q) begin
          case (sel)
            WB_ALU, WB_PC4: begin
              if (bus.ex_wb_en_i && (bus.ex_rd_i != '0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.ex_rd_i;
                rf_wdata_d = (sel == WB_PC4) ? bus.ex_pc_plus4_i : bus.ex_result_i;
              end
            end
            WB_LOAD: begin
              if (al_misaligned || al_illegal) begin
                load_err_d = 1'b1;
              end else begin
                state_d   = WAIT_LOAD;
                ld_rd_d   = bus.ex_rd_i;
                ld_f3_d   = bus.ex_funct3_i;
                ld_off_d  = bus.ex_result_i[1:0];
                ld_wben_d = bus.ex_wb_en_i;
                cnt_d     = '0;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        if (bus.dmem_rvalid_i) begin
          state_d = IDLE;
          if (ld_wben_q && (ld_rd_q != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = al_data;
          end
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          state_d    = IDLE;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ex_ready_d     = (state_d == IDLE);
    pending_load_d = (state_d == WAIT_LOAD);
    pending_rd_d   = pending_load_d ? ld_rd_d : '0;
  end

  // State and registered outputs
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state_q        <= IDLE;
      ex_ready_q     <= 1'b1;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      load_err_q     <= 1'b0;
      pending_load_q <= 1'b0;
      pending_rd_q   <= '0;
      ld_rd_q        <= '0;
      ld_f3_q        <= '0;
      ld_off_q       <= '0;
      ld_wben_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      ex_ready_q     <= ex_ready_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      load_err_q     <= load_err_d;
      pending_load_q <= pending_load_d;
      pending_rd_q   <= pending_rd_d;
      ld_rd_q        <= ld_rd_d;
      ld_f3_q        <= ld_f3_d;
      ld_off_q       <= ld_off_d;
      ld_wben_q      <= ld_wben_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.ex_ready_o     = ex_ready_q;
  assign bus.rf_we_o        = rf_we_q;
  assign bus.rf_waddr_o     = rf_waddr_q;
  assign bus.rf_wdata_o     = rf_wdata_q;
  assign bus.load_err_o     = load_err_q;
  assign bus.pending_load_o = pending_load_q;
  assign bus.pending_rd_o   = pending_rd_q;

endmodule

// File: tb/tb_brq_writeback.sv
// Self-checking bench for brq_writeback (TimeoutCycles = 4).
module tb_brq_writeback;

  localparam int TO = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  brq_writeback_if #(.DataWidth(32), .AddrRegWidth(5)) bus ();

  brq_writeback #(
    .DataWidth(32),
    .AddrRegWidth(5),
    .TimeoutCycles(TO)
  ) dut (
    .brq_clk(clk),
    .brq_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Output vector {ready, we, waddr, wdata, pending, pending_rd, err}; address/data
  // fields are don't-care while their qualifier is low.
  function automatic logic [45:0] mk(input logic rdy, input logic we, input logic [4:0] wa,
                                     input logic [31:0] wd, input logic pl,
                                     input logic [4:0] prd, input logic err);
    return {rdy, we, (we ? wa : 5'd0), (we ? wd : 32'd0), pl, (pl ? prd : 5'd0), err};
  endfunction

  function automatic logic [45:0] obs();
    return mk(bus.ex_ready_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o,
              bus.pending_load_o, bus.pending_rd_o, bus.load_err_o);
  endfunction

  function automatic logic [45:0] raw();
    return {bus.ex_ready_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o,
            bus.pending_load_o, bus.pending_rd_o, bus.load_err_o};
  endfunction

  // Reference: load result from word data, byte offset and funct3
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] v;
    int o;
    o = int'(off);
    case (f3)
      3'd0, 3'd4: begin
        v = (w / (32'd1 << (8 * o))) % 32'd256;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w / (32'd1 << (16 * (o / 2)))) % 32'd65536;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit ref_bad(input logic [1:0] off, input logic [2:0] f3);
    int o;
    o = int'(off);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
           (((f3 == 3'd1) || (f3 == 3'd5)) && (o % 2 == 1)) ||
           ((f3 == 3'd2) && (o != 0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.ex_valid_i    = 1'b0;
    bus.ex_wb_en_i    = 1'b0;
    bus.ex_wb_sel_i   = 2'd0;
    bus.ex_rd_i       = 5'd0;
    bus.ex_result_i   = 32'd0;
    bus.ex_pc_plus4_i = 32'd0;
    bus.ex_funct3_i   = 3'd0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = 32'd0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic en, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] pc4, input logic [2:0] f3);
    bus.ex_valid_i    = 1'b1;
    bus.ex_wb_sel_i   = sel;
    bus.ex_wb_en_i    = en;
    bus.ex_rd_i       = rd;
    bus.ex_result_i   = res;
    bus.ex_pc_plus4_i = pc4;
    bus.ex_funct3_i   = f3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    step();
    step();
    n_tests++;
    if (raw() !== {1'b1, 45'd0}) begin
      n_fail++;
      $display("FAIL reset_in got=%h exp=%h", raw(), {1'b1, 45'd0});
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (raw() !== {1'b1, 45'd0}) begin
      n_fail++;
      $display("FAIL reset_after got=%h exp=%h", raw(), {1'b1, 45'd0});
    end
  endtask

  task automatic test_alu();
    issue(2'd0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 3'd0);
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(1, 1, 5'd5, 32'h1234, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL alu_write got=%h exp=%h", obs(), mk(1, 1, 5'd5, 32'h1234, 0, 0, 0));
    end
    step();
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL alu_one_cycle got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    issue(2'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0, 3'd0);
    step();
    issue(2'd2, 1'b1, 5'd1, 32'h5555_0000, 32'h0000_0104, 3'd0);
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL b2b_x0 got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 0));
    end
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(1, 1, 5'd1, 32'h104, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL b2b_pc4 got=%h exp=%h", obs(), mk(1, 1, 5'd1, 32'h104, 0, 0, 0));
    end
    issue(2'd3, 1'b1, 5'd4, 32'h1111_1111, 32'h2222_2222, 3'd0);
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rsvd_sel got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_lb();
    issue(2'd1, 1'b1, 5'd7, 32'h0000_1003, 32'h0, 3'd0);
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs() !== mk(0, 0, 0, 0, 1, 5'd7, 0)) begin
        n_fail++;
        $display("FAIL lb_pending[%0d] got=%h exp=%h", i, obs(), mk(0, 0, 0, 0, 1, 5'd7, 0));
      end
      if (i < 2) step();
    end
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'h80FF_0000;
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(1, 1, 5'd7, 32'hFFFF_FF80, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL lb_data got=%h exp=%h", obs(), mk(1, 1, 5'd7, 32'hFFFF_FF80, 0, 0, 0));
    end
  endtask

  task automatic test_lhu_lw();
    issue(2'd1, 1'b1, 5'd12, 32'h0000_2002, 32'h0, 3'd5);
    step();
    clear_in();
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hBEEF_0011;
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(1, 1, 5'd12, 32'h0000_BEEF, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL lhu_data got=%h exp=%h", obs(), mk(1, 1, 5'd12, 32'h0000_BEEF, 0, 0, 0));
    end
    issue(2'd1, 1'b1, 5'd13, 32'h0000_3001, 32'h0, 3'd2);
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 1)) begin
      n_fail++;
      $display("FAIL lw_misaligned got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 1));
    end
    step();
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL err_pulse_width got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_timeout();
    issue(2'd1, 1'b1, 5'd3, 32'h0000_4000, 32'h0, 3'd2);
    step();
    clear_in();
    for (int i = 0; i < TO; i++) begin
      n_tests++;
      if (obs() !== mk(0, 0, 0, 0, 1, 5'd3, 0)) begin
        n_fail++;
        $display("FAIL to_wait[%0d] got=%h exp=%h", i, obs(), mk(0, 0, 0, 0, 1, 5'd3, 0));
      end
      step();
    end
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 1)) begin
      n_fail++;
      $display("FAIL to_err got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 1));
    end
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'h1234_5678;
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL to_stray got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid_wait();
    issue(2'd1, 1'b1, 5'd9, 32'h0000_5000, 32'h0, 3'd2);
    step();
    clear_in();
    n_tests++;
    if (obs() !== mk(0, 0, 0, 0, 1, 5'd9, 0)) begin
      n_fail++;
      $display("FAIL rmw_pending got=%h exp=%h", obs(), mk(0, 0, 0, 0, 1, 5'd9, 0));
    end
    rst = 1'b1;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hCAFE_F00D;
    step();
    rst = 1'b0;
    clear_in();
    n_tests++;
    if (raw() !== {1'b1, 45'd0}) begin
      n_fail++;
      $display("FAIL rmw_reset got=%h exp=%h", raw(), {1'b1, 45'd0});
    end
    step();
    n_tests++;
    if (obs() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rmw_after got=%h exp=%h", obs(), mk(1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [1:0]  sel;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] res, pc4, rdata;
    logic [2:0]  f3;
    logic [45:0] exp;
    int          d;
    for (int t = 0; t < 200; t++) begin
      sel = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      res = $urandom;
      pc4 = $urandom;
      f3  = 3'($urandom_range(0, 7));
      issue(sel, en, rd, res, pc4, f3);
      step();
      clear_in();
      if (sel == 2'd1) begin
        if (ref_bad(res[1:0], f3)) exp = mk(1, 0, 0, 0, 0, 0, 1);
        else                       exp = mk(0, 0, 0, 0, 1, rd, 0);
        n_tests++;
        if (obs() !== exp) begin
          n_fail++;
          $display("FAIL rnd_load_accept t=%0d got=%h exp=%h", t, obs(), exp);
        end
        if (!ref_bad(res[1:0], f3)) begin
          d = $urandom_range(0, TO + 1);
          for (int k = 0; k < TO; k++) begin
            rdata = $urandom;
            bus.dmem_rvalid_i = (k == d);
            bus.dmem_rdata_i  = rdata;
            // Upstream keeps offering work while the stage is stalled
            bus.ex_valid_i    = 1'($urandom_range(0, 1));
            bus.ex_wb_sel_i   = 2'd0;
            bus.ex_wb_en_i    = 1'b1;
            bus.ex_rd_i       = 5'($urandom_range(1, 31));
            bus.ex_result_i   = $urandom;
            step();
            clear_in();
            if (k == d)          exp = mk(1, en && (rd != 0), rd, ref_load(rdata, res[1:0], f3), 0, 0, 0);
            else if (k == TO - 1) exp = mk(1, 0, 0, 0, 0, 0, 1);
            else                 exp = mk(0, 0, 0, 0, 1, rd, 0);
            n_tests++;
            if (obs() !== exp) begin
              n_fail++;
              $display("FAIL rnd_load_wait t=%0d k=%0d got=%h exp=%h", t, k, obs(), exp);
            end
            if (k == d) break;
          end
        end
      end else begin
        exp = mk(1, (sel != 2'd3) && en && (rd != 0), rd, (sel == 2'd2) ? pc4 : res, 0, 0, 0);
        n_tests++;
        if (obs() !== exp) begin
          n_fail++;
          $display("FAIL rnd_nonload t=%0d got=%h exp=%h", t, obs(), exp);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = $urandom;
        step();
        clear_in();
        n_tests++;
        if (obs() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
          n_fail++;
          $display("FAIL rnd_stray t=%0d got=%h exp=%h", t, obs(), mk(1, 0, 0, 0, 0, 0, 0));
        end
      end
    end
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    n_tests = 0;
    n_fail  = 0;
    clear_in();
    test_reset();
    test_alu();
    test_back_to_back();
    test_lb();
    test_lhu_lw();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
